// File: rtl/fetch_unit.sv
// Instruction fetch unit: credit-limited request issue, per-request PC queue,
// in-order instruction buffer, and redirect flush with stale-response dropping.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_target,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        fetch_err
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW:0] CREDITS = (CW+1)'(DEPTH);

  logic [31:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;
  logic [CW-1:0] buf_cnt_q, buf_cnt_d;
  logic [AW-1:0] pcq_wr_q, pcq_wr_d, pcq_rd_q, pcq_rd_d;
  logic [AW-1:0] buf_wr_q, buf_wr_d, buf_rd_q, buf_rd_d;
  logic          err_q, err_d;

  logic [31:0] pcq_q      [DEPTH];
  logic [31:0] buf_pc_q   [DEPTH];
  logic [31:0] buf_data_q [DEPTH];

  logic          accept, pop, live_resp, push;
  logic [CW:0]   credit_used;

  assign instr_valid = (buf_cnt_q != '0);
  assign instr       = instr_valid ? buf_data_q[buf_rd_q] : '0;
  assign instr_pc    = instr_valid ? buf_pc_q[buf_rd_q]   : '0;
  assign imem_addr   = pc_q;
  assign fetch_err   = err_q;

  // A flush wins over a pop; a response is live only when no stale ones remain.
  assign pop       = instr_valid && instr_ready && !redirect;
  assign live_resp = imem_rvalid && (drop_q == '0);
  assign push      = live_resp && !redirect;

  // Credits cover both in-flight requests and buffered entries, so a returning
  // response always has a free slot; a same-cycle pop frees one immediately.
  assign credit_used = {1'b0, out_q} + {1'b0, buf_cnt_q} - (CW+1)'(pop);
  assign imem_req    = rst_n && !redirect && (drop_q == '0) && (credit_used < CREDITS);
  assign accept      = imem_req && imem_ready;

  always_comb begin
    pc_d      = pc_q;
    err_d     = err_q;
    out_d     = out_q;
    drop_d    = drop_q;
    pcq_wr_d  = pcq_wr_q;
    pcq_rd_d  = pcq_rd_q;
    buf_wr_d  = buf_wr_q;
    buf_rd_d  = buf_rd_q;
    buf_cnt_d = buf_cnt_q;

    if (redirect && (redirect_target[1:0] != 2'b00)) begin
      err_d = 1'b1;
    end

    if (redirect) begin
      pc_d      = {redirect_target[31:2], 2'b00};
      out_d     = '0;
      // Everything still in flight (live or already stale) becomes stale.
      drop_d    = drop_q + out_q - CW'(imem_rvalid);
      pcq_wr_d  = '0;
      pcq_rd_d  = '0;
      buf_wr_d  = '0;
      buf_rd_d  = '0;
      buf_cnt_d = '0;
    end else begin
      if (accept) begin
        pc_d     = pc_q + 32'd4;
        pcq_wr_d = pcq_wr_q + AW'(1);
      end
      if (accept && !live_resp) begin
        out_d = out_q + CW'(1);
      end else if (!accept && live_resp) begin
        out_d = out_q - CW'(1);
      end
      if (imem_rvalid && (drop_q != '0)) begin
        drop_d = drop_q - CW'(1);
      end
      if (live_resp) begin
        pcq_rd_d = pcq_rd_q + AW'(1);
      end
      if (push) begin
        buf_wr_d = buf_wr_q + AW'(1);
      end
      if (pop) begin
        buf_rd_d = buf_rd_q + AW'(1);
      end
      if (push && !pop) begin
        buf_cnt_d = buf_cnt_q + CW'(1);
      end else if (!push && pop) begin
        buf_cnt_d = buf_cnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      err_q     <= 1'b0;
      out_q     <= '0;
      drop_q    <= '0;
      pcq_wr_q  <= '0;
      pcq_rd_q  <= '0;
      buf_wr_q  <= '0;
      buf_rd_q  <= '0;
      buf_cnt_q <= '0;
    end else begin
      pc_q      <= pc_d;
      err_q     <= err_d;
      out_q     <= out_d;
      drop_q    <= drop_d;
      pcq_wr_q  <= pcq_wr_d;
      pcq_rd_q  <= pcq_rd_d;
      buf_wr_q  <= buf_wr_d;
      buf_rd_q  <= buf_rd_d;
      buf_cnt_q <= buf_cnt_d;
    end
  end

  // Storage needs no reset: entries are only visible through valid pointers/count.
  always_ff @(posedge clk) begin
    if (accept) begin
      pcq_q[pcq_wr_q] <= pc_q;
    end
    if (push) begin
      buf_pc_q[buf_wr_q]   <= pcq_q[pcq_rd_q];
      buf_data_q[buf_wr_q] <= imem_rdata;
    end
  end

endmodule
